// File: rtl/vad_mac_pkg.sv
// Shared defaults and FSM encoding for the MAC frame controller.
// Imported by mac_ctrl and mac_frame_shreg.
package vad_mac_pkg;

   localparam int WORD_W_DEF  = 3;
   localparam int N_WORDS_DEF = 36;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   // Counter width for values 0..n-1, at least one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_frame_shreg.sv
// Loadable frame shift register for the MAC feed path.
// The top word is presented; each shift brings the next word up.
module mac_frame_shreg
   import vad_mac_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int N_WORDS = N_WORDS_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic                      shift,
   input  logic [WORD_W*N_WORDS-1:0] din,
   output logic [WORD_W-1:0]         word
);

   localparam int FRAME_W = WORD_W * N_WORDS;

   logic [FRAME_W-1:0] q;

   // Capture a whole frame, then move words up one slot per shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {q[FRAME_W-WORD_W-1:0], {WORD_W{1'b0}}};
      end
   end

   assign word = q[FRAME_W-1 -: WORD_W];

endmodule

// File: rtl/mac_ctrl.sv
// Frame-to-MAC sequencer: feeds words, collects the result, hands it off.
// Optional WAIT timeout is enabled by defining MAC_CTRL_TIMEOUT_EN.
module mac_ctrl
   import vad_mac_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int N_WORDS = N_WORDS_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WORD_W*N_WORDS-1:0] frame_data,
   input  logic                      frame_valid,
   output logic                      frame_ready,
   output logic [WORD_W-1:0]         mac_in,
   output logic                      mac_in_vld,
   output logic                      mac_clr,
   input  logic [1:0]                mac_out,
   input  logic                      mac_done,
   output logic [1:0]                res_data,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      busy,
   output logic [7:0]                frame_cnt,
   output logic [1:0]                err
);

   localparam int CNT_W = cnt_width(N_WORDS);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

   if (N_WORDS < 2 || TIMEOUT < 1) begin : g_bad_cfg
      $error("mac_ctrl: N_WORDS must be >= 2 and TIMEOUT >= 1");
   end

   state_t            state;
   logic [CNT_W-1:0]  word_cnt;
   logic [WORD_W-1:0] shreg_word;
   logic              hs;
   logic              early_err;
   logic              tmo_err;

`ifdef MAC_CTRL_TIMEOUT_EN
   localparam int TMO_W = cnt_width(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   logic [TMO_W-1:0] tmo_cnt;
`else
   assign tmo_err = 1'b0;
`endif

   assign frame_ready = (state == S_IDLE);
   assign hs          = frame_valid & frame_ready;
   assign mac_clr     = hs;
   assign mac_in_vld  = (state == S_FEED);
   assign mac_in      = mac_in_vld ? shreg_word : '0;
   assign res_valid   = (state == S_OUT);
   assign busy        = (state != S_IDLE);
   assign err         = {tmo_err, early_err};

   mac_frame_shreg #(
      .WORD_W  (WORD_W),
      .N_WORDS (N_WORDS)
   ) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (hs),
      .shift (mac_in_vld),
      .din   (frame_data),
      .word  (shreg_word)
   );

   // Sequence a frame through FEED/WAIT/OUT and track count and errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         word_cnt  <= '0;
         res_data  <= '0;
         frame_cnt <= '0;
         early_err <= 1'b0;
`ifdef MAC_CTRL_TIMEOUT_EN
         tmo_cnt   <= '0;
         tmo_err   <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (hs) begin
                  state    <= S_FEED;
                  word_cnt <= '0;
               end
            end
            S_FEED: begin
               if (mac_done) begin
                  early_err <= 1'b1;
               end
               if (word_cnt == LAST_WORD) begin
                  state    <= S_WAIT;
                  word_cnt <= '0;
`ifdef MAC_CTRL_TIMEOUT_EN
                  tmo_cnt  <= '0;
`endif
               end else begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (mac_done) begin
                  res_data <= mac_out;
                  state    <= S_OUT;
               end
`ifdef MAC_CTRL_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  tmo_err <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            S_OUT: begin
               if (res_ready) begin
                  frame_cnt <= frame_cnt + 8'd1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed self-checking bench for mac_ctrl.
// Covers feed order, result hand-off, back-to-back, reset, errors, wrap.
module tb_mac_ctrl;

   localparam int WORD_W  = 3;
   localparam int N_WORDS = 36;
   localparam int FRAME_W = WORD_W * N_WORDS;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [FRAME_W-1:0] frame_data = '0;
   logic               frame_valid = 1'b0;
   logic               frame_ready;
   logic [WORD_W-1:0]  mac_in;
   logic               mac_in_vld;
   logic               mac_clr;
   logic [1:0]         mac_out = 2'b00;
   logic               mac_done = 1'b0;
   logic [1:0]         res_data;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic               busy;
   logic [7:0]         frame_cnt;
   logic [1:0]         err;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic [1:0] exp_err = 2'b00;

   mac_ctrl #(
      .WORD_W  (WORD_W),
      .N_WORDS (N_WORDS),
      .TIMEOUT (64)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .mac_in      (mac_in),
      .mac_in_vld  (mac_in_vld),
      .mac_clr     (mac_clr),
      .mac_out     (mac_out),
      .mac_done    (mac_done),
      .res_data    (res_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Seed 0 is the reference frame starting 2,6,2,1.
   function automatic logic [WORD_W-1:0] word_of(input int seed,
                                                 input int k);
      if (seed == 0 && k < 4) begin
         case (k)
            0:       return 3'd2;
            1:       return 3'd6;
            2:       return 3'd2;
            default: return 3'd1;
         endcase
      end
      return 3'((k * (seed + 5) + seed + 3) % 8);
   endfunction

   function automatic logic [FRAME_W-1:0] mk_frame(input int seed);
      logic [FRAME_W-1:0] f;
      f = '0;
      for (int k = 0; k < N_WORDS; k++)
         f[FRAME_W-1-WORD_W*k -: WORD_W] = word_of(seed, k);
      return f;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mac_in"}, mac_in, 0);
      chk({tag, "_vld"}, mac_in_vld, 0);
      chk({tag, "_clr"}, mac_clr, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_cnt"}, frame_cnt, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      frame_valid = 1'b0;
      mac_done = 1'b0;
      res_ready = 1'b0;
      #2;
      chk_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_rdy", frame_ready, 1);
      exp_cnt = 8'd0;
      exp_err = 2'b00;
   endtask

   // Handshake a frame and check all N_WORDS feed cycles.
   task automatic feed_frame(input int seed, input int early,
                             input bit keep);
      frame_data = mk_frame(seed);
      frame_valid = 1'b1;
      #1;
      chk("hs_clr", mac_clr, 1);
      chk("hs_rdy", frame_ready, 1);
      tick();
      if (!keep) frame_valid = 1'b0;
      for (int k = 0; k < N_WORDS; k++) begin
         mac_done = (k == early);
         mac_out = (k == early) ? 2'b01 : 2'b00;
         chk("feed_word", mac_in, word_of(seed, k));
         chk("feed_vld", mac_in_vld, 1);
         chk("feed_rdy", frame_ready, 0);
         chk("feed_clr", mac_clr, 0);
         chk("feed_busy", busy, 1);
         tick();
      end
      mac_done = 1'b0;
      mac_out = 2'b00;
      if (early >= 0) exp_err[0] = 1'b1;
      chk("wait_vld", mac_in_vld, 0);
      chk("wait_mac_in", mac_in, 0);
      chk("wait_err", err, exp_err);
   endtask

   task automatic result_phase(input int wait_cyc, input logic [1:0] mo,
                               input int hold);
      for (int t = 0; t < wait_cyc; t++) begin
         chk("wait_busy", busy, 1);
         chk("wait_res_valid", res_valid, 0);
         chk("wait_rdy", frame_ready, 0);
         tick();
      end
      mac_done = 1'b1;
      mac_out = mo;
      tick();
      mac_done = 1'b0;
      mac_out = 2'b00;
      for (int h = 0; h < hold; h++) begin
         chk("out_valid", res_valid, 1);
         chk("out_data", res_data, mo);
         chk("out_cnt", frame_cnt, exp_cnt);
         chk("out_rdy", frame_ready, 0);
         tick();
      end
      res_ready = 1'b1;
      #1;
      chk("acc_valid", res_valid, 1);
      chk("acc_data", res_data, mo);
      tick();
      res_ready = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      chk("acc_cnt", frame_cnt, exp_cnt);
      chk("acc_res_valid", res_valid, 0);
      chk("acc_busy", busy, 0);
      chk("acc_rdy", frame_ready, 1);
      chk("acc_err", err, exp_err);
   endtask

   task automatic run_frame(input int seed, input int early,
                            input int wait_cyc, input logic [1:0] mo,
                            input int hold, input bit keep);
      feed_frame(seed, early, keep);
      result_phase(wait_cyc, mo, hold);
   endtask

   initial begin
      do_reset();

      // Reference frame, result three cycles into WAIT, 5 stalled cycles.
      run_frame(0, -1, 3, 2'b10, 5, 1'b0);
      chk("first_cnt", frame_cnt, 8'd1);

      // Back-to-back frames with frame_valid held high.
      do_reset();
      for (int i = 0; i < 3; i++)
         run_frame(i + 1, -1, 1, 2'b01, 0, 1'b1);
      frame_valid = 1'b0;
      chk("b2b_cnt", frame_cnt, 8'd3);

      // Reset during FEED at word 20 discards the frame.
      do_reset();
      frame_data = mk_frame(7);
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      chk("pre_abort_word", mac_in, word_of(7, 20));
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      chk("abort_rdy", frame_ready, 1);
      rst_n = 1'b1;
      tick();
      run_frame(7, -1, 0, 2'b11, 1, 1'b0);
      chk("abort_cnt", frame_cnt, 8'd1);

      // Early mac_done at FEED word 10.
      run_frame(9, 10, 2, 2'b11, 1, 1'b0);
      chk("early_err", err, 2'b01);
      chk("early_res", res_data, 2'b11);

`ifdef MAC_CTRL_TIMEOUT_EN
      feed_frame(3, -1, 1'b0);
      for (int t = 0; t < 64; t++) begin
         chk("tmo_busy", busy, 1);
         chk("tmo_res_valid", res_valid, 0);
         tick();
      end
      exp_err[1] = 1'b1;
      chk("tmo_idle", busy, 0);
      chk("tmo_err", err, exp_err);
      chk("tmo_cnt", frame_cnt, exp_cnt);
`else
      feed_frame(3, -1, 1'b0);
      result_phase(100, 2'b01, 0);
      chk("notmo_err1", err[1], 0);
`endif

      // 256 completed frames wrap the counter back to 0.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         run_frame(i % 5, -1, 0, 2'(i), 0, 1'b0);
         if (i == 254) chk("wrap_255", frame_cnt, 8'd255);
      end
      chk("wrap_0", frame_cnt, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 Parameter WORD_W, default 3, width of one MAC input word.
REQ-002 Parameter N_WORDS, default 36, words per frame (frame width FRAME_W = WORD_W*N_WORDS = 108).
REQ-003 Parameter TIMEOUT, default 64, maximum WAIT cycles for mac_done.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 frame_data  input  FRAME_W  frame to feed; word 0 in bits [FRAME_W-1:FRAME_W-WORD_W].
REQ-007 frame_valid / frame_ready  input / output  1 / 1  frame handshake; transfer when both high on a rising edge.
REQ-008 mac_in  output  WORD_W  word driven to the MAC.
REQ-009 mac_in_vld  output  1  mac_in carries a valid word this cycle.
REQ-010 mac_clr  output  1  one-cycle pulse that clears the MAC accumulator.
REQ-011 mac_out  input  2  MAC result.
REQ-012 mac_done  input  1  MAC result valid.
REQ-013 res_data / res_valid / res_ready  output / output / input  2 / 1 / 1  result handshake.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_cnt  output  8  count of completed results, wraps 255->0.
REQ-016 err  output  2  sticky flags: bit0 early mac_done, bit1 timeout.

Function
REQ-017 FSM states: IDLE, FEED, WAIT, OUT.
REQ-018 IDLE: frame_ready=1; on handshake, latch frame_data, pulse mac_clr for that same cycle, go to FEED.
REQ-019 FEED: mac_in_vld=1 for exactly N_WORDS consecutive cycles; cycle k (0-based) drives word k; mac_in=0 whenever mac_in_vld=0.
REQ-020 First FEED cycle is the cycle immediately after the frame handshake (latency 1); after word N_WORDS-1, go to WAIT.
REQ-021 mac_done high during FEED: ignored for the result, set err[0], FEED continues.
REQ-022 WAIT: on first cycle with mac_done=1, capture mac_out into res_data and go to OUT; res_valid is high from the next cycle.
REQ-023 OUT: res_valid=1 and res_data held stable until res_ready=1; on that cycle increment frame_cnt and go to IDLE.
REQ-024 frame_ready=0 in FEED, WAIT and OUT; frame_valid outside IDLE has no effect.
REQ-025 Word counter width is ceil(log2(N_WORDS)) bits; it never exceeds N_WORDS-1.
REQ-026 err bits clear only on reset.

Reset
REQ-027 rst_n low, including mid-frame, forces IDLE immediately.
REQ-028 Reset values: mac_in=0, mac_in_vld=0, mac_clr=0, res_data=0, res_valid=0, busy=0, frame_cnt=0, err=0; frame_ready=1 after reset release.
REQ-029 A partially fed frame is discarded on reset, with no result and no frame_cnt change.

Configuration
REQ-030 With MAC_CTRL_TIMEOUT_EN defined: WAIT counts cycles; if mac_done is still absent after TIMEOUT cycles, set err[1], return to IDLE, no result, frame_cnt unchanged.
REQ-031 Without MAC_CTRL_TIMEOUT_EN: WAIT waits indefinitely, no timeout counter exists, and err[1] is tied to 0.

Structure
REQ-032 Shared package vad_mac_pkg holds the WORD_W, N_WORDS and TIMEOUT defaults and the FSM state encoding.
REQ-033 Sub-module mac_frame_shreg (a loadable FRAME_W shift register shifting WORD_W bits per cycle, MSB word out) provides the FEED datapath.

Verification
REQ-034 Frame 108'h... with words 2,6(-2),2,1,... pushed -> mac_clr pulses once; mac_in shows words in order over 36 cycles starting 1 cycle after handshake; mac_in_vld high exactly 36 cycles.
REQ-035 Model returns mac_done=1, mac_out=2'b10 three cycles into WAIT, res_ready held 0 for 5 cycles -> res_valid stays high with res_data=2'b10 for 5 cycles; frame_cnt goes 0->1 on accept.
REQ-036 frame_valid held high across 3 back-to-back frames -> frame_ready only in IDLE; 3 results; frame_cnt=3.
REQ-037 rst_n low at FEED word 20 -> all outputs at reset values at once; next frame is fed from word 0.
REQ-038 mac_done pulsed at FEED word 10 -> err=2'b01; result still taken from the WAIT-phase mac_done.
REQ-039 With MAC_CTRL_TIMEOUT_EN, no mac_done -> IDLE after 64 WAIT cycles, err[1]=1, res_valid never asserted; 256 completed frames -> frame_cnt wraps to 0.
